// File: rtl/uart_rx_byte_buffer_pkg.sv
// uart_rx_byte_buffer_pkg: shared clock constant and state encodings for the UART RX byte buffer.
// Rev 1.0
`default_nettype none

package uart_rx_byte_buffer_pkg;

  localparam int UART_CLK_HZ = 40_000_000;

  localparam logic [1:0] RX_IDLE_ENC  = 2'd0;
  localparam logic [1:0] RX_START_ENC = 2'd1;
  localparam logic [1:0] RX_DATA_ENC  = 2'd2;
  localparam logic [1:0] RX_STOP_ENC  = 2'd3;

  localparam logic [1:0] HS_EMPTY_ENC   = 2'd0;
  localparam logic [1:0] HS_PRESENT_ENC = 2'd1;
  localparam logic [1:0] HS_HOLD_ENC    = 2'd2;

  typedef enum logic [1:0] {
    RX_IDLE  = RX_IDLE_ENC,
    RX_START = RX_START_ENC,
    RX_DATA  = RX_DATA_ENC,
    RX_STOP  = RX_STOP_ENC
  } rx_state_t;

  typedef enum logic [1:0] {
    HS_EMPTY   = HS_EMPTY_ENC,
    HS_PRESENT = HS_PRESENT_ENC,
    HS_HOLD    = HS_HOLD_ENC
  } hs_state_t;

  // Rounded clk cycles per UART bit for a given baud rate.
  function automatic int baud_to_clks(input int baud);
    return (UART_CLK_HZ + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte_buffer_fifo.sv
// byte_fifo: circular show-ahead FIFO with extra-bit pointers and synchronous flush.
// Rev 1.0
`default_nettype none

module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  // A push into a full FIFO is dropped so stored bytes are never overwritten.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_byte_buffer.sv
// uart_rx_byte_buffer: 8N1 UART receiver feeding a byte FIFO and a rdy/uld decoder handshake.
// Rev 1.0
`default_nettype none

module uart_rx_byte_buffer
  import uart_rx_byte_buffer_pkg::*;
#(
  parameter int CLKS_PER_BIT = baud_to_clks(115_200),
  parameter int FIFO_DEPTH   = 8,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    byte_out,
  output logic                          byte_rdy,
  input  logic                          byte_uld,
  output logic                          framing_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic rx_meta, rx_s;

  rx_state_t         rx_state, rx_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [7:0]        shift, shift_next;
  logic              fe_next, ov_next, push;

  hs_state_t         hs_state, hs_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [7:0]        out_next;
  logic              rdy_next, pop;

  logic [7:0]        fifo_dout;
  logic              fifo_empty, fifo_full;

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shift),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Synchroniser presets high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_state    <= rx_next;
      baud_cnt    <= baud_next;
      bit_cnt     <= bit_next;
      shift       <= shift_next;
      framing_err <= fe_next;
      overrun     <= ov_next;
    end
  end

  always_comb begin
    rx_next    = rx_state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift;
    fe_next    = 1'b0;
    ov_next    = 1'b0;
    push       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        baud_next = '0;
        if (!rx_s) begin
          rx_next  = RX_START;
          bit_next = '0;
        end
      end
      RX_START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_next = '0;
          rx_next   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next  = '0;
          shift_next = {rx_s, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next = '0;
          rx_next   = RX_IDLE;
          if (!rx_s)          fe_next = 1'b1;
          else if (fifo_full) ov_next = 1'b1;
          else                push    = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_state <= HS_EMPTY;
      hold_cnt <= '0;
      byte_out <= '0;
      byte_rdy <= 1'b0;
    end else begin
      hs_state <= hs_next;
      hold_cnt <= hold_next;
      byte_out <= out_next;
      byte_rdy <= rdy_next;
    end
  end

  // HOLD leaves only once the minimum hold has elapsed and uld has been released.
  always_comb begin
    hs_next   = hs_state;
    hold_next = hold_cnt;
    out_next  = byte_out;
    rdy_next  = byte_rdy;
    pop       = 1'b0;
    case (hs_state)
      HS_EMPTY: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          out_next = fifo_dout;
          rdy_next = 1'b1;
          hs_next  = HS_PRESENT;
        end
      end
      HS_PRESENT: begin
        if (byte_uld) begin
          rdy_next  = 1'b0;
          hold_next = '0;
          hs_next   = HS_HOLD;
        end
      end
      HS_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          if (!byte_uld) hs_next = HS_EMPTY;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: hs_next = HS_EMPTY;
    endcase
  end

endmodule

`default_nettype wire
